alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that decodes a 32-bit RV32I instruction into the 4-bit ALU opcode and selects the A/B operands, then registers them for the execute-stage ALU.
- Producer side of the ALU opcode interface; uses a valid/ready handshake on both sides plus a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, operand/data width.
- RESET_PC_ZERO, 1, when 1 the registered pc_out resets to 0; when 0 it resets to 32'hFFFF_FFFF (debug marker).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held/incoming work.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  instruction word.
- pc_in  input  XLEN  instruction PC.
- rs1_data  input  XLEN  register-file read data for rs1.
- rs2_data  input  XLEN  register-file read data for rs2.
- out_valid  output  1  registered ALU issue valid.
- out_ready  input  1  execute stage accepts.
- alu_a  output  XLEN  ALU operand A.
- alu_b  output  XLEN  ALU operand B.
- alu_opcode  output  4  ALU operation code.
- rd  output  5  destination register.
- reg_write  output  1  result is written back.
- is_branch  output  1  branch-compare instruction.
- illegal  output  1  unsupported encoding.
- pc_out  output  XLEN  registered PC.

Behaviour:
- Opcode encoding is fixed: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- Transfer in occurs on in_valid&&in_ready; transfer out on out_valid&&out_ready. Latency is 1 cycle (accept at edge N, out_valid high after edge N).
- While out_valid&&!out_ready, all outputs hold stable.
- OP (0110011), by funct3:
  - 000 = ADD, or SUB when funct7=0100000.
  - 001 = SLL; 010 = SLT; 011 = SLTU; 100 = XOR.
  - 101 = SRL, or SRA when funct7=0100000.
  - 110 = OR; 111 = AND.
  - A=rs1, B=rs2.
  - funct7 other than 0000000 is illegal; the single exception is 0100000 with funct3 000 or 101.
- OP-IMM (0010011):
  - Same funct3 map, but 000 is always ADD.
  - B = sign-extended I-immediate; for shifts B = {27'b0, shamt}.
  - A shift with a bad funct7 is illegal.
- LUI: A=0, B={imm[31:12],12'b0}, ADD.
- AUIPC: A=pc_in, B=U-immediate, ADD.
- LOAD: A=rs1, B=I-immediate, ADD.
- STORE: A=rs1, B=S-immediate, ADD, reg_write=0.
- BRANCH:
  - A=rs1, B=rs2, reg_write=0, is_branch=1.
  - funct3 000/001 selects SUB; 100/101 selects SLT; 110/111 selects SLTU; 010/011 are illegal.
- JAL/JALR: A=pc_in, B=4, ADD, reg_write=1.
- Any other major opcode: illegal=1.
- When illegal=1: alu_opcode=ADD, A=B=0, reg_write=0, is_branch=0. The word is still passed downstream with out_valid=1.
- rd=instr[11:7]. reg_write is forced 0 when rd=0.
- flush:
  - At the next edge, out_valid=0 and any skid entry is dropped.
  - An input offered in the same cycle is not captured.
  - flush has priority over accept.
  - in_ready is not gated by flush.
- Reset (rst_n low, asynchronous):
  - out_valid=0; alu_a=alu_b=0; alu_opcode=0; rd=0; reg_write=0; is_branch=0; illegal=0.
  - pc_out=0, or all-ones when RESET_PC_ZERO=0.
  - Skid entry invalid; in_ready=1 as soon as reset is asserted.
  - A reset mid-transfer discards everything; no partial output appears after release.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a one-entry skid register; in_ready = !skid_valid (registered, independent of out_ready).
  - If an accept occurs while out_valid&&!out_ready, the decoded word goes to the skid. It moves to the output on the next out_ready transfer.
  - Order is preserved.
- Undefined: no skid; in_ready = !out_valid || out_ready (combinational path from out_ready).

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_opcode=0, alu_a=5, alu_b=7, rd=3, reg_write=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> alu_opcode=7, alu_b=3, reg_write=1, illegal=0. SRLI with funct7=0100001 -> illegal=1, reg_write=0.
- BLTU (funct3=110) -> alu_opcode=4, is_branch=1, reg_write=0. LUI x1,0x12345 -> alu_a=0, alu_b=0x12345000, opcode 0.
- out_ready=0 for 3 cycles while in_valid=1:
  - No skid: outputs stable and in_ready=0.
  - With ALU_ISSUE_SKID_EN: second instruction captured in skid, in_ready drops.
  - On release, both words emerge in order on consecutive cycles.
- flush and in_valid asserted together while out_valid=1 -> next cycle out_valid=0, new instruction not issued, skid empty.
- Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0 immediately (asynchronous), all outputs at reset values, in_ready=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage that decodes RV32I into ALU opcode/operands and registers them.
//   Ports: clk, rst_n (async, active low), flush (sync kill)
//          in_valid/in_ready, instr, pc_in, rs1_data, rs2_data   (decode side)
//          out_valid/out_ready, alu_a, alu_b, alu_opcode, rd,
//          reg_write, is_branch, illegal, pc_out                  (execute side)
//   Macro ALU_ISSUE_SKID_EN adds a one-entry skid so in_ready is a pure register output.
module alu_issue_stage #(
    parameter int XLEN          = 32,
    parameter int RESET_PC_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_opcode,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    localparam logic [3:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [XLEN-1:0] RST_PC = RESET_PC_ZERO != 0 ? {XLEN{1'b0}} : {XLEN{1'b1}};

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rw;
        logic            br;
        logic            ill;
    } word_t;

    localparam word_t RST_WORD = '{pc: RST_PC, default: '0};

    function automatic logic [3:0] f3_op(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  f3_op = alt ? SUB : ADD;
            3'b001:  f3_op = SLL;
            3'b010:  f3_op = SLT;
            3'b011:  f3_op = SLTU;
            3'b100:  f3_op = XOR;
            3'b101:  f3_op = alt ? SRA : SRL;
            3'b110:  f3_op = OR;
            3'b111:  f3_op = AND;
        endcase
    endfunction

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic            alt, shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;
    word_t           dec, out_q, out_d;
    logic            out_v_q, out_v_d, accept;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign alt   = f7 == 7'b0100000;
    assign shift = f3[1:0] == 2'b01;
    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

    always_comb begin
        dec    = '0;
        dec.pc = pc_in;
        dec.rd = instr[11:7];
        dec.rw = 1'b1;
        case (opc)
            OPC_OP: begin
                dec.op  = f3_op(f3, alt);
                dec.a   = rs1_data;
                dec.b   = rs2_data;
                dec.ill = f7 != 7'b0 && !(alt && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_IMM: begin
                dec.op  = f3_op(f3, f3 == 3'b101 && alt);
                dec.a   = rs1_data;
                dec.b   = shift ? XLEN'(instr[24:20]) : imm_i;
                dec.ill = shift && f7 != 7'b0 && !(f3 == 3'b101 && alt);
            end
            OPC_LUI:   dec.b = imm_u;
            OPC_AUIPC: begin
                dec.a = pc_in;
                dec.b = imm_u;
            end
            OPC_LOAD: begin
                dec.a = rs1_data;
                dec.b = imm_i;
            end
            OPC_STORE: begin
                dec.a  = rs1_data;
                dec.b  = imm_s;
                dec.rw = 1'b0;
            end
            OPC_BR: begin
                dec.op  = f3[2] ? (f3[1] ? SLTU : SLT) : SUB;
                dec.a   = rs1_data;
                dec.b   = rs2_data;
                dec.rw  = 1'b0;
                dec.br  = 1'b1;
                dec.ill = f3[2:1] == 2'b01;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a = pc_in;
                dec.b = XLEN'(4);
            end
            default: dec.ill = 1'b1;
        endcase
        // Illegal words still travel downstream, but as a harmless ADD 0,0 with no side effects.
        if (dec.ill) begin
            dec.op = ADD;
            dec.a  = '0;
            dec.b  = '0;
            dec.rw = 1'b0;
            dec.br = 1'b0;
        end
        if (dec.rd == 5'd0) dec.rw = 1'b0;
    end

    assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
    word_t skid_q, skid_d;
    logic  skid_v_q, skid_v_d;

    assign in_ready = !skid_v_q;

    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (!out_v_q || out_ready) begin
            // A full skid never coincides with an accept, so the skid word always goes first.
            out_v_d  = skid_v_q || accept;
            out_d    = skid_v_q ? skid_q : accept ? dec : out_q;
            skid_v_d = 1'b0;
        end else if (accept) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q   <= RST_WORD;
            skid_v_q <= 1'b0;
        end else begin
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    assign in_ready = !out_v_q || out_ready;

    always_comb begin
        out_d   = out_q;
        out_v_d = out_v_q;
        if (flush) begin
            out_v_d = 1'b0;
        end else if (!out_v_q || out_ready) begin
            out_v_d = accept;
            out_d   = accept ? dec : out_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= RST_WORD;
            out_v_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            out_v_q <= out_v_d;
        end
    end

    assign out_valid  = out_v_q;
    assign alu_a      = out_q.a;
    assign alu_b      = out_q.b;
    assign alu_opcode = out_q.op;
    assign rd         = out_q.rd;
    assign reg_write  = out_q.rw;
    assign is_branch  = out_q.br;
    assign illegal    = out_q.ill;
    assign pc_out     = out_q.pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench with a queue-based reference model for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, reg_write, is_branch, illegal;
    logic [31:0] instr = '0, pc_in = '0, rs1_data = '0, rs2_data = '0;
    logic [31:0] alu_a, alu_b, pc_out;
    logic [3:0]  alu_opcode;
    logic [4:0]  rd;
    int          n_chk = 0, n_fail = 0;

    // Nibble i holds the base ALU code for funct3=i; SUB/SRA are the base code plus one.
    localparam logic [31:0] BASE_TBL = 32'h98654320;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .rd(rd), .reg_write(reg_write), .is_branch(is_branch),
        .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    logic [107:0] act_w;
    assign act_w = {alu_opcode, alu_a, alu_b, pc_out, rd, reg_write, is_branch, illegal};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [107:0] model(input logic [31:0] ins, pc, r1, r2);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic [31:0] a, b, ii, iu, is;
        logic        rw, br, ill, al;
        f7 = ins[31:25];
        f3 = ins[14:12];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iu = {ins[31:12], 12'h000};
        op = BASE_TBL[f3*4 +: 4];
        a = 0; b = 0; rw = 1; br = 0; ill = 0;
        case (ins[6:0])
            7'h33: begin
                a = r1; b = r2; al = f7 == 7'h20;
                ill = !(f7 == 0 || (al && (f3 == 0 || f3 == 5)));
                op = op + {3'b0, al};
            end
            7'h13: begin
                a = r1; b = (f3 == 1 || f3 == 5) ? {27'b0, ins[24:20]} : ii;
                al = f3 == 5 && f7 == 7'h20;
                ill = (f3 == 1 || f3 == 5) && !(f7 == 0 || al);
                op = op + {3'b0, al};
            end
            7'h37: begin op = 0; b = iu; end
            7'h17: begin op = 0; a = pc; b = iu; end
            7'h03: begin op = 0; a = r1; b = ii; end
            7'h23: begin op = 0; a = r1; b = is; rw = 0; end
            7'h63: begin
                a = r1; b = r2; rw = 0; br = 1;
                ill = f3 == 2 || f3 == 3;
                op = f3 < 2 ? 4'd1 : f3 < 6 ? 4'd3 : 4'd4;
            end
            7'h6F, 7'h67: begin op = 0; a = pc; b = 4; end
            default: ill = 1;
        endcase
        if (ill) begin op = 0; a = 0; b = 0; rw = 0; br = 0; end
        if (ins[11:7] == 0) rw = 0;
        return {op, a, b, pc, ins[11:7], rw, br, ill};
    endfunction

    // Reference: a FIFO of words in flight; its head must be on the outputs whenever it is non-empty.
    logic [107:0] q[$];
    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        bit rdy, acc, tx;
        if (rst_n) begin
`ifdef ALU_ISSUE_SKID_EN
            rdy = q.size() < 2;
`else
            rdy = q.size() == 0 || out_ready;
`endif
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, rdy);
            if (q.size() != 0) chk("word", act_w, q[0]);
            acc = in_valid && rdy;
            tx = q.size() != 0 && out_ready;
            if (flush) q.delete();
            else begin
                if (tx) void'(q.pop_front());
                if (acc) q.push_back(model(instr, pc_in, rs1_data, rs2_data));
            end
        end
    end

    task automatic drive(input logic [31:0] ins, p, a, b);
        instr = ins; pc_in = p; rs1_data = a; rs2_data = b; in_valid = 1;
    endtask

    task automatic issue1(input logic [31:0] ins, p, a, b);
        @(posedge clk); #1;
        drive(ins, p, a, b);
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ins, p, a, b);
        bit done;
        done = 0;
        drive(ins, p, a, b);
        for (int k = 0; k < 32 && !done; k++) begin
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end
    endtask

    logic [31:0] stream [24] = '{
        32'h002081B3, 32'h402081B3, 32'h40335293, 32'h42335293, 32'h0020E063, 32'h123450B7,
        32'h00001217, 32'hFFC0A303, 32'h0020A423, 32'h008000EF, 32'h000080E7, 32'h0000007F,
        32'h00208033, 32'h022081B3, 32'h0020A063, 32'hFFF00093, 32'h40209093, 32'h0020B1B3,
        32'h0020E1B3, 32'h0020F1B3, 32'h0020C1B3, 32'h4020D1B3, 32'h00208063, 32'h0020D063
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_word", act_w, 108'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;

        issue1(32'h002081B3, 32'h100, 5, 7);
        chk("add_valid", out_valid, 1);
        chk("add_word", {alu_opcode, alu_a, alu_b, rd, reg_write, pc_out},
            {4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'h100});
        issue1(32'h40335293, 32'h104, 32'h80000000, 0);
        chk("srai_word", {alu_opcode, alu_a, alu_b, reg_write, illegal},
            {4'd7, 32'h80000000, 32'd3, 1'b1, 1'b0});
        issue1(32'h42335293, 32'h108, 9, 9);
        chk("srli_bad", {out_valid, illegal, reg_write, alu_a, alu_b}, {3'b110, 64'h0});
        issue1(32'h0020E063, 32'h10C, 1, 2);
        chk("bltu", {alu_opcode, is_branch, reg_write}, {4'd4, 2'b10});
        issue1(32'h123450B7, 32'h110, 3, 4);
        chk("lui", {alu_opcode, alu_a, alu_b, rd}, {4'd0, 32'h0, 32'h12345000, 5'd1});

        // Stall: I1 held for three cycles while I2 is offered.
        @(posedge clk); #1;
        drive(32'h002081B3, 32'h200, 32'h11, 32'h22);
        out_ready = 1;
        @(posedge clk); #1;
        drive(32'h402081B3, 32'h204, 32'h33, 32'h44);
        out_ready = 0;
        @(negedge clk);
        chk("stall1_a", {out_valid, alu_a}, {1'b1, 32'h11});
`ifdef ALU_ISSUE_SKID_EN
        chk("stall1_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
`else
        chk("stall1_ready", in_ready, 0);
        @(posedge clk); #1;
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, alu_a, alu_opcode, in_ready}, {1'b1, 32'h11, 4'd0, 1'b0});
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("release_a", alu_a, 32'h11);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("second_out", {out_valid, alu_a, alu_opcode}, {1'b1, 32'h33, 4'd1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("drained", out_valid, 0);

        // Flush with a new offer while a word is held.
        @(posedge clk); #1;
        drive(32'h002081B3, 32'h300, 1, 2);
        out_ready = 1;
        @(posedge clk); #1;
        drive(32'h402081B3, 32'h304, 3, 4);
        out_ready = 0;
        @(posedge clk); #1;
        drive(32'h0020F1B3, 32'h308, 5, 6);
        flush = 1;
        out_ready = 1;
        @(posedge clk); #1;
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        chk("flush_valid", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_empty", out_valid, 0);

        // Asynchronous reset in the middle of a stall.
        @(posedge clk); #1;
        drive(32'h002081B3, 32'h400, 1, 2);
        out_ready = 1;
        @(posedge clk); #1;
        drive(32'h402081B3, 32'h404, 3, 4);
        out_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 0;
        in_valid = 0;
        #1;
        chk("arst_state", {out_valid, in_ready, act_w}, {2'b01, 108'h0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        @(negedge clk);
        chk("post_rst1", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst2", out_valid, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) send(stream[i], $urandom, $urandom, $urandom);
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("final_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
